// File: rtl/uart_cmd_decoder_pkg.sv
// uart_cmd_pkg: frame-parser state encoding and the header byte shared with the transmit-side frame builder.
package uart_cmd_pkg;
   localparam logic [7:0] DEF_HEADER = 8'hA5;
   typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD} state_t;
endpackage

// File: rtl/uart_cmd_decoder_cmd_timer.sv
// cmd_timer: clear/enable counter that saturates at MAX; expired flags the edge where the count lands on MAX and stays set while saturated.
module cmd_timer #(
   parameter int MAX = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(MAX + 1);
   localparam logic [W-1:0] LIM = W'(MAX);
   logic [W-1:0] cnt, nxt;
   always_comb nxt = clr ? '0 : (en && cnt != LIM) ? cnt + 1'b1 : cnt;
   assign expired = nxt == LIM;
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else cnt <= nxt;
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: validates header/command/inverted-command frames, drives disp/motor and a link watchdog.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER       = DEF_HEADER,
   parameter int         BYTE_GAP_CYC = 500_000,
   parameter int         TIMEOUT_CYC  = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] disp,
   output logic       motor,
   output logic       stale,
   output logic       frame_ok,
   output logic       frame_err
);
   state_t state;
   logic [7:0] cmd_q, disp_nxt;
   logic commit, stale_nxt, gap_exp, wd_exp;
   assign commit = rx_valid && state == GOT_CMD && rx_data == ~cmd_q;
   always_comb begin
      disp_nxt  = commit ? cmd_q : disp;
      stale_nxt = commit ? 1'b0 : (stale | wd_exp);
   end
   cmd_timer #(.MAX(BYTE_GAP_CYC)) u_gap (
      .clk(clk), .rst(rst), .clr(rx_valid || state == IDLE), .en(1'b1), .expired(gap_exp)
   );
   cmd_timer #(.MAX(TIMEOUT_CYC)) u_wd (
      .clk(clk), .rst(rst), .clr(commit), .en(1'b1), .expired(wd_exp)
   );
   // A byte arriving in the expiry cycle takes priority over the gap error.
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         cmd_q     <= '0;
         disp      <= '0;
         motor     <= 1'b0;
         stale     <= 1'b1;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_ok  <= commit;
         frame_err <= 1'b0;
         disp      <= disp_nxt;
         stale     <= stale_nxt;
         motor     <= disp_nxt[7] & ~stale_nxt;
         if (rx_valid)
            case (state)
               IDLE:    if (rx_data == HEADER) state <= GOT_HDR;
               GOT_HDR: begin
                  cmd_q <= rx_data;
                  state <= GOT_CMD;
               end
               GOT_CMD: if (commit) state <= IDLE;
               else begin
                  frame_err <= 1'b1;
                  state     <= rx_data == HEADER ? GOT_HDR : IDLE;
               end
               default: state <= IDLE;
            endcase
         else if (gap_exp) begin
            frame_err <= 1'b1;
            state     <= IDLE;
         end
      end
endmodule
